// File: rtl/v20_filter_param.sv
// Shared constants and state type for the v20 trapezoidal shaper event sequencer.
package v20_filter_param;

   localparam int unsigned DATA_W_DEF   = 16;
   localparam int unsigned KL_W_DEF     = 5;
   localparam int unsigned M_W_DEF      = 8;
   localparam int unsigned TS_W_DEF     = 32;
   localparam int unsigned PIPE_LAT_DEF = 4;
   localparam int unsigned CNT_W_DEF    = 16;

   localparam int unsigned K_DEF = 10;
   localparam int unsigned L_DEF = 6;
   localparam int unsigned M_DEF = 16;

   typedef enum logic [2:0] {
      FLUSH,
      ARMED,
      PEAK,
      HOLDOFF,
      REPORT
   } state_t;

endpackage

// File: rtl/v20_peak_hold.sv
// Running-maximum register: load starts a new pulse, update keeps the larger sample.
module v20_peak_hold #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         update,
   input  logic [W-1:0] din,
   output logic [W-1:0] peak
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         peak <= '0;
      end else if (load) begin
         peak <= din;
      end else if (update && (din > peak)) begin
         peak <= din;
      end
   end

endmodule

// File: rtl/v20_filter_ctrl.sv
// Event sequencer for the v20 shaper: owns k/l/M, flushes the filter, captures peak and
// timestamp per pulse, rejects pile-up and presents events over valid/ready.
module v20_filter_ctrl
   import v20_filter_param::*;
#(
   parameter int unsigned SIZE_FILTER_DATA = DATA_W_DEF,
   parameter int unsigned KL_W             = KL_W_DEF,
   parameter int unsigned M_W              = M_W_DEF,
   parameter int unsigned TS_W             = TS_W_DEF,
   parameter int unsigned PIPE_LAT         = PIPE_LAT_DEF,
   parameter int unsigned CNT_W            = CNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_wr,
   input  logic [KL_W-1:0]             cfg_k,
   input  logic [KL_W-1:0]             cfg_l,
   input  logic [M_W-1:0]              cfg_m,
   input  logic [SIZE_FILTER_DATA-1:0] thr,
   input  logic [SIZE_FILTER_DATA-1:0] flt_data,
   output logic                        flt_clear,
   output logic [KL_W-1:0]             flt_k,
   output logic [KL_W-1:0]             flt_l,
   output logic [M_W-1:0]              flt_m,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [SIZE_FILTER_DATA-1:0] evt_amp,
   output logic [TS_W-1:0]             evt_ts,
   output logic [CNT_W-1:0]            pileup_cnt,
   output logic [CNT_W-1:0]            drop_cnt,
   output logic                        cfg_err,
   output logic                        busy
);

   localparam int unsigned PH_W = KL_W + 1 + $clog2(PIPE_LAT + 1);
   localparam logic [PH_W-1:0] RST_FLUSH_M1 = PH_W'(K_DEF + L_DEF + PIPE_LAT - 1);

   state_t state, state_nx;

   logic [PH_W-1:0] ph_cnt;
   logic [KL_W:0]   span, cfg_span;
   logic [PH_W-1:0] span_m1, flush_len, flush_m1;
   logic            above, prev_above;
   logic            armed_again, pile, pile_now;
   logic            ph_done;

   logic peak_load, peak_upd, ts_cap, cfg_load;
   logic ph_load_span, ph_dec, pile_inc, drop_inc;

   logic [TS_W-1:0] ts;

   assign above    = (flt_data >= thr);
   assign ph_done  = (ph_cnt == '0);
   assign span     = {1'b0, flt_k} + {1'b0, flt_l};
   assign cfg_span = {1'b0, cfg_k} + {1'b0, cfg_l};
   // A zero span still spends one cycle per phase so the counter never underflows.
   assign span_m1   = (span == '0) ? '0 : PH_W'(span) - PH_W'(1);
   assign flush_len = PH_W'(cfg_span) + PH_W'(PIPE_LAT);
   assign flush_m1  = (flush_len == '0) ? '0 : flush_len - PH_W'(1);
   assign pile_now  = pile | (armed_again & above);

   assign busy      = (state != ARMED);
   assign evt_valid = (state == REPORT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= FLUSH;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      peak_load    = 1'b0;
      peak_upd     = 1'b0;
      ts_cap       = 1'b0;
      cfg_load     = 1'b0;
      ph_load_span = 1'b0;
      ph_dec       = 1'b0;
      pile_inc     = 1'b0;
      drop_inc     = 1'b0;
      case (state)
         FLUSH: begin
            if (ph_done) state_nx = ARMED;
            else         ph_dec   = 1'b1;
         end
         ARMED: begin
            if (cfg_wr) begin
               cfg_load = 1'b1;
               state_nx = FLUSH;
            end else if (above) begin
               peak_load    = 1'b1;
               ts_cap       = 1'b1;
               ph_load_span = 1'b1;
               state_nx     = PEAK;
            end
         end
         PEAK: begin
            peak_upd = 1'b1;
            if (ph_done) begin
               ph_load_span = 1'b1;
               state_nx     = HOLDOFF;
            end else begin
               ph_dec = 1'b1;
            end
         end
         HOLDOFF: begin
            if (ph_done) begin
               pile_inc = pile_now;
               state_nx = pile_now ? ARMED : REPORT;
            end else begin
               ph_dec = 1'b1;
            end
         end
         REPORT: begin
            if (evt_ready)                 state_nx = ARMED;
            else if (above && !prev_above) drop_inc = 1'b1;
         end
         default: state_nx = FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         flt_k       <= KL_W'(K_DEF);
         flt_l       <= KL_W'(L_DEF);
         flt_m       <= M_W'(M_DEF);
         flt_clear   <= 1'b1;
         ph_cnt      <= RST_FLUSH_M1;
         evt_ts      <= '0;
         ts          <= '0;
         pileup_cnt  <= '0;
         drop_cnt    <= '0;
         cfg_err     <= 1'b0;
         prev_above  <= 1'b0;
         armed_again <= 1'b0;
         pile        <= 1'b0;
      end else begin
         ts         <= ts + TS_W'(1);
         prev_above <= above;
         cfg_err    <= cfg_wr && (state != ARMED);
         flt_clear  <= cfg_load;
         if (cfg_load) begin
            flt_k  <= cfg_k;
            flt_l  <= cfg_l;
            flt_m  <= cfg_m;
            ph_cnt <= flush_m1;
         end else if (ph_load_span) begin
            ph_cnt <= span_m1;
         end else if (ph_dec) begin
            ph_cnt <= ph_cnt - PH_W'(1);
         end
         if (ts_cap) evt_ts <= ts;
         if (pile_inc && (pileup_cnt != '1)) pileup_cnt <= pileup_cnt + CNT_W'(1);
         if (drop_inc && (drop_cnt != '1))   drop_cnt   <= drop_cnt + CNT_W'(1);
         // Pile-up needs a dip below thr and then a new crossing, both inside holdoff.
         if (state == HOLDOFF) begin
            if (!above) armed_again <= 1'b1;
            pile <= pile_now;
         end else begin
            armed_again <= 1'b0;
            pile        <= 1'b0;
         end
      end
   end

   v20_peak_hold #(
      .W(SIZE_FILTER_DATA)
   ) u_peak_hold (
      .clk    (clk),
      .reset  (reset),
      .load   (peak_load),
      .update (peak_upd),
      .din    (flt_data),
      .peak   (evt_amp)
   );

endmodule

// File: tb/tb_v20_filter_ctrl.sv
// Self-checking bench for v20_filter_ctrl: directed scenarios plus random pulses against
// a timeline model that derives event outcomes from the recorded sample history.
module tb_v20_filter_ctrl;

   localparam int PIPE = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [4:0]  cfg_k = '0;
   logic [4:0]  cfg_l = '0;
   logic [7:0]  cfg_m = '0;
   logic [15:0] thr = 16'd100;
   logic [15:0] flt_data = '0;
   logic        evt_ready = 1'b0;
   logic        flt_clear;
   logic [4:0]  flt_k, flt_l;
   logic [7:0]  flt_m;
   logic        evt_valid;
   logic [15:0] evt_amp;
   logic [31:0] evt_ts;
   logic [15:0] pileup_cnt, drop_cnt;
   logic        cfg_err, busy;

   v20_filter_ctrl #(
      .SIZE_FILTER_DATA(16), .KL_W(5), .M_W(8), .TS_W(32), .PIPE_LAT(4), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m),
      .thr(thr), .flt_data(flt_data), .flt_clear(flt_clear), .flt_k(flt_k), .flt_l(flt_l),
      .flt_m(flt_m), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_amp(evt_amp),
      .evt_ts(evt_ts), .pileup_cnt(pileup_cnt), .drop_cnt(drop_cnt), .cfg_err(cfg_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Timeline model: cycle n is the n-th cycle after reset release, so ts == n.
   int n, t_flush, t_armed, t_trig;
   bit ev_active;
   int mk, ml, mm;
   int exp_pile, exp_drop, exp_amp, exp_ts;
   bit err_prev;
   int hist[$];
   int sq[$];
   bit rdy, rnd_rdy, cw_req;
   int cw_k, cw_l, cw_m;
   int n_err, n_checks;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, obs, expv);
      end
   endtask

   task automatic model_reset();
      n = 0; t_flush = 0; t_armed = 10 + 6 + PIPE; t_trig = 0; ev_active = 0;
      mk = 10; ml = 6; mm = 16; exp_pile = 0; exp_drop = 0; exp_amp = 0; exp_ts = 0;
      err_prev = 0; hist.delete(); sq.delete();
   endtask

   task automatic tick();
      int d, sp, r, pk;
      bit busy_e, valid_e, err_next, seen_low, piled;
      sp      = mk + ml;
      busy_e  = (n < t_armed) || ev_active;
      valid_e = ev_active && (n >= t_trig + 2 * sp + 1);
      chk("busy", busy, busy_e);
      chk("evt_valid", evt_valid, valid_e);
      chk("flt_clear", flt_clear, n == t_flush);
      chk("cfg_err", cfg_err, err_prev);
      chk("flt_k", flt_k, mk);
      chk("flt_l", flt_l, ml);
      chk("flt_m", flt_m, mm);
      chk("pileup_cnt", pileup_cnt, exp_pile);
      chk("drop_cnt", drop_cnt, exp_drop);
      if (valid_e) begin
         chk("evt_amp", evt_amp, exp_amp);
         chk("evt_ts", evt_ts, exp_ts);
      end

      d = (sq.size() > 0) ? sq.pop_front() : int'($urandom_range(0, int'(thr) - 1));
      if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
      flt_data  = 16'(d);
      evt_ready = rdy;
      cfg_wr    = cw_req;
      cfg_k     = 5'(cw_k);
      cfg_l     = 5'(cw_l);
      cfg_m     = 8'(cw_m);
      hist.push_back(d);

      err_next = cw_req && busy_e;
      if (n >= t_armed) begin
         if (!ev_active) begin
            if (cw_req) begin
               mk = cw_k; ml = cw_l; mm = cw_m;
               t_flush = n + 1;
               t_armed = n + 1 + cw_k + cw_l + PIPE;
            end else if (d >= int'(thr)) begin
               ev_active = 1;
               t_trig    = n;
            end
         end else begin
            r = t_trig + 2 * sp + 1;
            if (n == r - 1) begin
               seen_low = 0; piled = 0;
               for (int i = t_trig + sp + 1; i <= t_trig + 2 * sp; i++) begin
                  if (hist[i] < int'(thr)) seen_low = 1;
                  else if (seen_low)       piled = 1;
               end
               pk = 0;
               for (int i = t_trig; i <= t_trig + sp; i++) if (hist[i] > pk) pk = hist[i];
               if (piled) begin
                  if (exp_pile < 65535) exp_pile++;
                  ev_active = 0;
               end else begin
                  exp_amp = pk;
                  exp_ts  = t_trig;
               end
            end else if (n >= r) begin
               if (rdy) ev_active = 0;
               else if ((d >= int'(thr)) && (hist[n - 1] < int'(thr)) && (exp_drop < 65535))
                  exp_drop++;
            end
         end
      end
      err_prev = err_next;
      cw_req   = 0;
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic run(input int c);
      for (int i = 0; i < c; i++) tick();
   endtask

   task automatic pulse(input int pk, input int w);
      for (int i = 0; i < w; i++)
         sq.push_back((i == w / 2) ? pk : int'($urandom_range(int'(thr), pk)));
   endtask

   task automatic base(input int c);
      for (int i = 0; i < c; i++) sq.push_back(int'($urandom_range(0, int'(thr) - 1)));
   endtask

   task automatic cfg(input int k, input int l, input int m);
      cw_req = 1; cw_k = k; cw_l = l; cw_m = m;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0; cfg_wr = 1'b0; flt_data = '0; evt_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_evt_valid", evt_valid, 1'b0);
      chk("rst_flt_clear", flt_clear, 1'b1);
      chk("rst_pileup", pileup_cnt, 0);
      chk("rst_drop", drop_cnt, 0);
      model_reset();
      reset = 1'b1;
   endtask

   initial begin
      n_err = 0; n_checks = 0; rdy = 1; rnd_rdy = 0; cw_req = 0;
      cw_k = 0; cw_l = 0; cw_m = 0;

      // 1: reset defaults, 20-cycle flush
      do_reset();
      run(25);
      chk("t1_armed_idle", busy, 1'b0);

      // 2: single pulse peaking at 500
      pulse(500, 7);
      run(60);

      // 3: second crossing 5 cycles into holdoff
      pulse(500, 4);
      base(18);
      pulse(300, 3);
      run(60);
      chk("t3_pileup", pileup_cnt, 1);

      // 4: stalled downstream, two crossings while reporting
      rdy = 0;
      pulse(450, 5);
      run(50);
      pulse(200, 3);
      base(6);
      pulse(250, 3);
      run(16);
      rdy = 1;
      run(20);
      chk("t4_drop", drop_cnt, 2);

      // 5: cfg in PEAK is rejected, in ARMED it reflushes
      pulse(600, 6);
      run(3);
      cfg(4, 2, 8);
      run(60);
      cfg(4, 2, 8);
      run(15);
      chk("t5_flt_k", flt_k, 4);
      pulse(700, 3);
      run(30);

      // 6: reset during PEAK drops the event
      pulse(800, 6);
      run(5);
      do_reset();
      run(40);

      // random pulses, random backpressure, occasional reconfiguration
      rnd_rdy = 1;
      for (int it = 0; it < 20; it++) begin
         int pk, w;
         if ($urandom_range(0, 4) == 0)
            cfg(int'($urandom_range(1, 12)), int'($urandom_range(0, 8)), int'($urandom_range(0, 255)));
         pk = int'($urandom_range(150, 4000));
         w  = int'($urandom_range(1, 6));
         pulse(pk, w);
         run(w + int'($urandom_range(0, 45)));
      end
      rnd_rdy = 0;
      rdy = 1;
      run(80);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
